ws2812_bit_enc: RTL
===================

Name: ws2812_bit_enc

Overview:
- Downstream line encoder for the WS2812 controller.
- Takes one data bit per request from the frame controller (bit_rdy/bit_data) and drives the single-wire WS2812 NRZ waveform: a high phase, then a low phase, with durations selected by the bit value.
- Pulses bit_done_out when a bit period completes, so the controller can present the next bit.
- Holds one pending bit, so back-to-back bits go out with no line gap.

Parameters:
- CNT_W, 8, width of the phase down-counter.
- T0H, 80, high-phase cycles for bit 0 (0.40 us at 200 MHz).
- T0L, 170, low-phase cycles for bit 0 (0.85 us).
- T1H, 160, high-phase cycles for bit 1 (0.80 us).
- T1L, 90, low-phase cycles for bit 1 (0.45 us).

Ports:
- clk_in  input  1  system clock; single clock domain.
- rst_in  input  1  synchronous, active-high reset.
- bit_rdy_in  input  1  one-cycle request: bit_data_in is valid.
- bit_data_in  input  1  bit value to encode; sampled only when bit_rdy_in=1.
- bit_done_out  output  1  one-cycle pulse: a bit period has finished.
- data_out  output  1  WS2812 line drive.
- busy_out  output  1  encoder is active or a bit is pending.
- ovf_out  output  1  sticky flag: a request was dropped.

Behaviour:
- Reset, sampled on the clk_in edge while rst_in=1, forces:
  - state IDLE, counter 0, pending empty;
  - data_out=0, bit_done_out=0, busy_out=0, ovf_out=0.
  - Reset mid-bit: data_out returns low in the next cycle; the pending bit is discarded; no bit_done_out pulse.
- Outputs are registered.
- States: IDLE, HIGH, LOW.
  - data_out=1 exactly while the state is HIGH; otherwise 0.
- IDLE:
  - bit_rdy_in=1 → HIGH next cycle.
  - Latch the bit value; load counter with (bit ? T1H : T0H)-1.
- HIGH:
  - Counter decrements each cycle.
  - Counter==0 → LOW; load counter with (bit ? T1L : T0L)-1.
- LOW:
  - Counter decrements each cycle.
  - When counter==0:
    - bit_done_out=1 in the next cycle (one cycle only).
    - Pending valid → HIGH with the pending bit (counter loaded as in IDLE); pending cleared. No idle cycle is inserted.
    - Otherwise, bit_rdy_in=1 in this same cycle → accepted directly as from IDLE.
    - Otherwise → IDLE.
- Latency: request at cycle t → data_out high from t+1. Full bit period = TxH+TxL cycles; bit_done_out at t+TxH+TxL+1.
- Pending slot:
  - bit_rdy_in=1 while in HIGH, or in LOW with counter≠0, and slot empty → store bit_data_in in the pending slot.
  - Slot already full → request dropped; ovf_out set next cycle and held until reset.
  - Current and pending bits are never altered by a dropped request.
- busy_out = (state≠IDLE) | pending valid.
- Line low while IDLE is legal: extra low time is tolerated by WS2812 if below about 50 us. The controller is responsible for the reset gap.
- Width rule: every timing parameter must be ≥1 and ≤2^CNT_W. Counter compares are on CNT_W bits with no wrap; the implementation rejects illegal values at elaboration.

Decomposition:
- Package ws2812_pkg:
  - state enum (IDLE, HIGH, LOW);
  - default timing constants T0H/T0L/T1H/T1L;
  - CNT_W.
  - The frame controller can import the same constants.
- One natural sub-module: pulse_timer.
  - Loadable CNT_W-bit down-counter.
  - Inputs: load, load value.
  - Output: zero flag.
  - Instantiated once; shared by both phases.

Test Plan:
- Reset then single bit '1' requested at cycle 0 → data_out high cycles 1–160, low 161–250, bit_done_out only at cycle 251, busy_out 0 from 251.
- Single bit '0' at cycle 0 → data_out high 1–80, low 81–250, bit_done_out at 251.
- Bit '1' at cycle 0, bit '0' at cycle 10 (pending) → second high phase starts at cycle 251 with no low gap. High 251–330, bit_done_out at 251 and 501, ovf_out stays 0.
- Requests at cycles 0, 5, 9 → third request dropped, ovf_out=1 from cycle 10 until reset. Only two bit periods are emitted.
- Request at cycle 250 (the last LOW cycle, pending empty) → HIGH at 251, identical to the pending path.
- rst_in asserted at cycle 100 during a '1' bit → data_out=0, busy_out=0 from 101. No bit_done_out; pending discarded; the next request encodes normally.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 line-encoding constants and encoder state type.
// The frame controller imports the same timing defaults.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int CNT_W = 8;
  localparam int T0H   = 80;   // 0.40 us at 200 MHz
  localparam int T0L   = 170;  // 0.85 us
  localparam int T1H   = 160;  // 0.80 us
  localparam int T1L   = 90;   // 0.45 us

  // A phase of t cycles loads t-1, so t must lie in 1..2^w.
  function automatic bit timing_ok(input int t, input int w);
    return (t >= 1) && (t <= (1 << w));
  endfunction

endpackage

// File: rtl/ws2812_bit_enc_pulse_timer.sv
// Loadable down-counter that times one line phase; zero marks the phase's last cycle.
module ws2812_bit_enc_pulse_timer
  import ws2812_pkg::*;
#(
  parameter int CNT_W = ws2812_pkg::CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ws2812_bit_enc.sv
// WS2812 NRZ bit encoder: one high/low phase pair per requested bit, with a
// one-deep pending slot so consecutive bits go out without a line gap.
module ws2812_bit_enc
  import ws2812_pkg::*;
#(
  parameter int CNT_W = ws2812_pkg::CNT_W,
  parameter int T0H   = ws2812_pkg::T0H,
  parameter int T0L   = ws2812_pkg::T0L,
  parameter int T1H   = ws2812_pkg::T1H,
  parameter int T1L   = ws2812_pkg::T1L
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic bit_rdy_in,
  input  logic bit_data_in,
  output logic bit_done_out,
  output logic data_out,
  output logic busy_out,
  output logic ovf_out
);

  if (!timing_ok(T0H, CNT_W) || !timing_ok(T0L, CNT_W) ||
      !timing_ok(T1H, CNT_W) || !timing_ok(T1L, CNT_W)) begin : g_bad_timing
    $error("ws2812_bit_enc: timing parameters must be within 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LD_T0H = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] LD_T0L = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0] LD_T1H = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] LD_T1L = CNT_W'(T1L - 1);

  state_t           state, state_nxt;
  logic             cur_bit, cur_bit_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic             pend_bit, pend_bit_nxt;
  logic             ovf_nxt, done_nxt, data_nxt, busy_nxt;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  ws2812_bit_enc_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cur_bit      <= 1'b0;
      pend_vld     <= 1'b0;
      pend_bit     <= 1'b0;
      ovf_out      <= 1'b0;
      bit_done_out <= 1'b0;
      data_out     <= 1'b0;
      busy_out     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cur_bit      <= cur_bit_nxt;
      pend_vld     <= pend_vld_nxt;
      pend_bit     <= pend_bit_nxt;
      ovf_out      <= ovf_nxt;
      bit_done_out <= done_nxt;
      data_out     <= data_nxt;
      busy_out     <= busy_nxt;
    end
  end

  // Next state, timer control and pending-slot bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    cur_bit_nxt  = cur_bit;
    pend_vld_nxt = pend_vld;
    pend_bit_nxt = pend_bit;
    ovf_nxt      = ovf_out;
    done_nxt     = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    case (state)
      IDLE: begin
        if (bit_rdy_in) begin
          state_nxt   = HIGH;
          cur_bit_nxt = bit_data_in;
          tmr_load    = 1'b1;
          tmr_val     = bit_data_in ? LD_T1H : LD_T0H;
        end
      end
      HIGH: begin
        if (tmr_zero) begin
          state_nxt = LOW;
          tmr_load  = 1'b1;
          tmr_val   = cur_bit ? LD_T1L : LD_T0L;
        end
      end
      LOW: begin
        if (tmr_zero) begin
          done_nxt = 1'b1;
          if (pend_vld) begin
            state_nxt    = HIGH;
            cur_bit_nxt  = pend_bit;
            pend_vld_nxt = 1'b0;
            tmr_load     = 1'b1;
            tmr_val      = pend_bit ? LD_T1H : LD_T0H;
          end else if (bit_rdy_in) begin
            state_nxt   = HIGH;
            cur_bit_nxt = bit_data_in;
            tmr_load    = 1'b1;
            tmr_val     = bit_data_in ? LD_T1H : LD_T0H;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A request while a bit is on the line queues it; the slot freed by a
    // pending bit moving to HIGH can take a request arriving that same cycle.
    if (bit_rdy_in && state != IDLE && !(state == LOW && tmr_zero && !pend_vld)) begin
      if (!pend_vld || (state == LOW && tmr_zero)) begin
        pend_vld_nxt = 1'b1;
        pend_bit_nxt = bit_data_in;
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

  // Registered line and status outputs follow the next-cycle state.
  always_comb begin
    data_nxt = (state_nxt == HIGH);
    busy_nxt = (state_nxt != IDLE) || pend_vld_nxt;
  end

endmodule
